xsync_chain: RTL
================

Name: xsync_chain

Overview:
- Parametrised multi-bit, multi-stage synchroniser model with metastability injection, for CDC verification netlists.
- Generalises the single-bit metastable flop model in three ways:
  - WIDTH independent bits.
  - STAGES-deep chain.
  - Per-bit random settle duration, which lets an unresolved value ripple down the chain.
- Flags unresolved values that escape the chain and output transitions.
- Keeps saturating event statistics.
- Replaces a synchroniser cell at a clock-domain crossing when the netlist is instrumented for formal X/metastability analysis.

Parameters:
- WIDTH, 1, number of independent bits.
- STAGES, 2, flop stages per bit (>=1).
- SETTLE_W, 3, width of each per-bit settle value.
- MAX_SETTLE, 4, clamp applied to injected settle values (<= 2^SETTLE_W-1).
- CNT_W, 16, statistics counter width.

Ports:
- CK  input  1  clock, rising edge.
- RS  input  1  asynchronous reset, active-low.
- D  input  WIDTH  data from source domain.
- V  input  WIDTH  per-bit setup/hold violation at this edge.
- rD  input  WIDTH  free random data, sampled at each edge.
- rV  input  WIDTH  free random metastability-enable per bit.
- rS  input  WIDTH*SETTLE_W  free random settle value per bit; bit i uses slice [i*SETTLE_W +: SETTLE_W].
- stats_clr  input  1  synchronous clear of statistics counters.
- Q  output  WIDTH  last-stage data.
- M  output  WIDTH  last-stage value unresolved (escape).
- T  output  WIDTH  last-stage bit changed at latest edge.
- viol_cnt  output  CNT_W  edges with any V bit set.
- esc_cnt  output  CNT_W  edges after which any M bit is set.

Behaviour:
- State per bit i, stage k (0..STAGES-1):
  - data[k][i] (1 bit).
  - cnt[k][i] (SETTLE_W bits).
  - Stage k is unresolved iff cnt[k][i] != 0.
- Reset (RS=0, asynchronous): all data, cnt, Q, M, T and both counters go to 0. This holds mid-operation and discards every pending unresolved value.
- Stage 0 at each edge:
  - V[i]=0: data <= D[i]; cnt <= 0. rV/rS are ignored.
  - V[i]=1, rV[i]=0: data <= rD[i]; cnt <= 0. This is a clean random resolution.
  - V[i]=1, rV[i]=1: data <= rD[i]; cnt <= min(rS_i, MAX_SETTLE).
- Stage k+1 at each edge:
  - If cnt[k][i] != 0: data[k+1][i] <= rD[i]; cnt[k+1][i] <= cnt[k][i]-1.
  - Otherwise: data[k+1][i] <= data[k][i]; cnt[k+1][i] <= 0.
- rD[i] is shared by all stages capturing bit i at the same edge. This is deterministic and intended.
- Outputs:
  - Q = data[STAGES-1].
  - M[i] = (cnt[STAGES-1][i] != 0).
  - T[i] is a register: it is set at an edge iff the new Q[i] differs from the previous Q[i], otherwise cleared.
- Latency: in violation-free operation a D change appears on Q after exactly STAGES edges. T pulses for one cycle on that edge.
- Escape condition: with STAGES=S, an injected settle value s reaches the output unresolved iff s >= S; M is then high for exactly min(s-S+1, 1) cycle per injection. Overlapping injections on the same bit keep M high in consecutive cycles.
- STAGES=1: Q is stage 0, and M is high for one cycle whenever an injection has s >= 1.
- Statistics:
  - viol_cnt increments on edges where |V.
  - esc_cnt increments on edges after which |M is 1.
  - Both counters saturate at all-ones and never wrap.
  - stats_clr=1 zeroes both counters at the edge, taking priority over an increment at the same edge.
- All random inputs are don't-care when not selected. No combinational path exists from any input to any output.

Optional Feature:
- Macro XSYNC_STATE_X_EN.
- Defined:
  - Q[i] is driven to X (via the tie-X cell) whenever M[i]=1, so escapes propagate as X into downstream logic.
  - M, T and the counters are unchanged.
- Undefined: Q always carries data[STAGES-1]. Escapes are visible only on M.

Test Plan:
- WIDTH=4, STAGES=2, reset released, D=4'hA held, V=0 -> Q=0 after edge 1, Q=4'hA after edge 2. T=4'hA for exactly one cycle. M=0. Both counters stay 0.
- V=4'b0001, rV=0, rD=4'b0000 at one edge with D=4'hF -> after 2 edges Q=4'hE. M=0. viol_cnt=1. esc_cnt=0.
- V=4'b0010, rV=4'b0010, rS bit1=2 -> M=4'b0010 for exactly one cycle, 2 edges later. Q[1]=rD[1] at the stage-1 edge. esc_cnt=1. With rS=1 instead -> M stays 0 and esc_cnt=0.
- rS=7 with MAX_SETTLE=4, STAGES=2 -> clamped to 4, giving M=1 for one cycle. Repeat with STAGES=4, s=4 -> M=1 for one cycle, 4 edges after injection.
- Inject s=3, then assert RS=0 one edge later -> Q, M, T and counters are 0 immediately, and no M pulse follows after release.
- CNT_W=2: V=1 for 5 edges -> viol_cnt=3 (saturated). stats_clr together with V at the same edge -> viol_cnt=0.

Source files
------------

// File: rtl/xsync_chain.sv
// -----------------------------------------------------------------------------
// xsync_chain
//
// Purpose:
//   Behavioural model of a WIDTH-bit, STAGES-deep synchroniser with
//   metastability injection, used in place of a real synchroniser cell at a
//   clock-domain crossing when the netlist is instrumented for
//   X/metastability analysis.
//
//   Each bit carries a settle counter alongside its data in every stage.
//   A non-zero counter means the stage holds an unresolved value.
//   While the counter is non-zero, the next stage captures free random data
//   and inherits the counter minus one. An unresolved value therefore
//   ripples down the chain until it settles. If it is still unresolved in
//   the last stage, it escapes and is flagged on M.
//
// Optional feature (macro XSYNC_STATE_X_EN):
//   When defined, Q[i] is forced to X while M[i] is high, so escapes
//   propagate as X into downstream logic. M, T and the statistics counters
//   are identical in both builds.
//
// Ports:
//   CK         in   1               clock, rising edge
//   RS         in   1               asynchronous reset, active-low
//   D          in   WIDTH           data from the source domain
//   V          in   WIDTH           per-bit setup/hold violation at this edge
//   rD         in   WIDTH           free random data
//   rV         in   WIDTH           free random metastability enable per bit
//   rS         in   WIDTH*SETTLE_W  free random settle value per bit
//                                   (bit i uses [i*SETTLE_W +: SETTLE_W])
//   stats_clr  in   1               synchronous clear of statistics counters
//   Q          out  WIDTH           last-stage data
//   M          out  WIDTH           last-stage value unresolved (escape)
//   T          out  WIDTH           last-stage bit changed at latest edge
//   viol_cnt   out  CNT_W           edges with any V bit set (saturating)
//   esc_cnt    out  CNT_W           edges after which any M bit is set
//                                   (saturating)
// -----------------------------------------------------------------------------
module xsync_chain #(
  parameter int WIDTH      = 1,
  parameter int STAGES     = 2,
  parameter int SETTLE_W   = 3,
  parameter int MAX_SETTLE = 4,
  parameter int CNT_W      = 16
) (
  input  logic                         CK,
  input  logic                         RS,
  input  logic [WIDTH-1:0]             D,
  input  logic [WIDTH-1:0]             V,
  input  logic [WIDTH-1:0]             rD,
  input  logic [WIDTH-1:0]             rV,
  input  logic [WIDTH*SETTLE_W-1:0]    rS,
  input  logic                         stats_clr,
  output logic [WIDTH-1:0]             Q,
  output logic [WIDTH-1:0]             M,
  output logic [WIDTH-1:0]             T,
  output logic [CNT_W-1:0]             viol_cnt,
  output logic [CNT_W-1:0]             esc_cnt
);

  // Injected settle values above MAX_SETTLE are clamped to MAX_SETTLE.
  function automatic logic [SETTLE_W-1:0] clamp_settle(input logic [SETTLE_W-1:0] s);
    if (s > SETTLE_W'(MAX_SETTLE)) return SETTLE_W'(MAX_SETTLE);
    return s;
  endfunction

  // Saturating increment: the counter holds at all-ones and never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  logic [STAGES-1:0][WIDTH-1:0]               r_data;
  logic [STAGES-1:0][WIDTH-1:0][SETTLE_W-1:0] r_cnt;
  logic [STAGES-1:0][WIDTH-1:0]               w_data_nxt;
  logic [STAGES-1:0][WIDTH-1:0][SETTLE_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]                           r_t;
  logic [CNT_W-1:0]                           r_viol;
  logic [CNT_W-1:0]                           r_esc;
  logic [WIDTH-1:0]                           w_m;
  logic [WIDTH-1:0]                           w_m_nxt;

  // Next-state of the whole chain
  always_comb begin
    w_data_nxt = '0;
    w_cnt_nxt  = '0;
    // Stage 0: clean capture, clean random resolution, or injection.
    for (int i = 0; i < WIDTH; i++) begin
      if (!V[i]) begin
        w_data_nxt[0][i] = D[i];
        w_cnt_nxt[0][i]  = '0;
      end else begin
        w_data_nxt[0][i] = rD[i];
        w_cnt_nxt[0][i]  = rV[i] ? clamp_settle(rS[i*SETTLE_W +: SETTLE_W]) : '0;
      end
    end
    // Later stages: an unresolved predecessor hands on random data together
    // with one less cycle of remaining settle time. rD[i] is deliberately
    // shared by every stage capturing bit i at the same edge.
    for (int k = 1; k < STAGES; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_cnt[k-1][i] != '0) begin
          w_data_nxt[k][i] = rD[i];
          w_cnt_nxt[k][i]  = r_cnt[k-1][i] - SETTLE_W'(1);
        end else begin
          w_data_nxt[k][i] = r_data[k-1][i];
          w_cnt_nxt[k][i]  = '0;
        end
      end
    end
  end

  // Escape flags now (from state) and after the coming edge (from next-state).
  always_comb begin
    w_m     = '0;
    w_m_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_m[i]     = (r_cnt[STAGES-1][i] != '0);
      w_m_nxt[i] = (w_cnt_nxt[STAGES-1][i] != '0);
    end
  end

  always_ff @(posedge CK or negedge RS) begin
    if (!RS) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_t    <= '0;
      r_viol <= '0;
      r_esc  <= '0;
    end else begin
      r_data <= w_data_nxt;
      r_cnt  <= w_cnt_nxt;
      r_t    <= w_data_nxt[STAGES-1] ^ r_data[STAGES-1];
      if (stats_clr) begin
        r_viol <= '0;
        r_esc  <= '0;
      end else begin
        if (|V)       r_viol <= sat_inc(r_viol);
        if (|w_m_nxt) r_esc  <= sat_inc(r_esc);
      end
    end
  end

`ifdef XSYNC_STATE_X_EN
  // Tie-X on escaped bits so the unresolved value poisons downstream logic.
  always_comb begin
    Q = '0;
    for (int i = 0; i < WIDTH; i++) begin
      Q[i] = w_m[i] ? 1'bx : r_data[STAGES-1][i];
    end
  end
`else
  assign Q = r_data[STAGES-1];
`endif

  assign M        = w_m;
  assign T        = r_t;
  assign viol_cnt = r_viol;
  assign esc_cnt  = r_esc;

endmodule
